step_count_sched: RTL
=====================

Name: step_count_sched

Overview:
- Scheduler that shares one 4-bit stepping counter (value register, +1 per step period) between two requesters.
- Arbitrates round-robin and latches the winner's target.
- Runs the counter from 0 up to the target, then pulses that requester's done.
- Sits between test/control agents and the shared counter datapath; the counter register lives inside this block.

Parameters:
- PERIOD, 1, clock cycles per increment step (legal range 1..255).
- CW, 4, counter/target width.
- PW, 8, period-counter width; PERIOD must be below 2**PW.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  2  request per requester; bit0 = requester 0
- tgt0  input  CW  target for requester 0, sampled at grant
- tgt1  input  CW  target for requester 1, sampled at grant
- gnt  output  2  one-hot grant, held for the whole run
- done  output  2  one-cycle completion pulse, one-hot
- value  output  CW  shared counter value
- busy  output  1  high in RUN or DONE

Behaviour:
- Clock and reset are fixed: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset (async assert, sync-safe release):
  - state=IDLE; gnt=0, done=0, value=0, busy=0.
  - Period counter=0; round-robin pointer favours requester 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - If any req bit is high at edge k, the arbiter picks a winner.
  - Only one requesting: that one wins.
  - Both requesting: the pointer side wins.
  - After edge k: gnt[winner]=1, latched target = tgt of winner, value=0, period counter=0, state=RUN, busy=1.
  - Pointer then moves to the other requester.
- RUN:
  - If value == latched target: go to DONE (no increment). Target 0 therefore spends exactly one cycle in RUN.
  - Else the period counter increments each cycle. When it reaches PERIOD-1, value <= value+1 and the counter returns to 0.
  - With PERIOD=1, value increments every cycle.
- DONE:
  - done[winner]=1 for exactly one cycle; gnt still held; value holds the final target.
  - Next edge: gnt=0, done=0, busy=0, state=IDLE. value holds until the next grant clears it.
- Requests:
  - Deasserting req during RUN is ignored; the run completes.
  - Changes on tgt0/tgt1 after grant are ignored.
  - A request still high in DONE is not granted until IDLE, so there is a minimum of one IDLE cycle between runs.
- Latency: from req sampled in IDLE to done = 1 + T*PERIOD + 1 cycles, where T = target. From done to next gnt = 2 edges.
- Width and wrap:
  - value never exceeds the target, so no wrap occurs; the maximum target 4'hF is legal.
  - Increment is modulo 2**CW by construction.
- Reset mid-run: everything returns to reset values immediately. No done pulse is issued for the aborted run.

Optional Feature:
- Macro: STEP_COUNT_SCHED_ABORT_EN.
- When defined:
  - Adds input port abort (1 bit).
  - abort high in RUN forces DONE on the next edge, with value frozen at its current count and done pulsed normally.
  - Also adds output aborted (1 bit), high alongside done when the run ended by abort.
  - abort in IDLE or DONE has no effect.
- When undefined: no abort/aborted ports; runs always complete to target.

Decomposition:
- Package step_count_sched_pkg:
  - state enum (IDLE, RUN, DONE).
  - localparam defaults for CW, PW, PERIOD.
  - Requester index constants REQ0=0, REQ1=1.
- One natural sub-module, rr_arb2: 2-way round-robin arbiter with req[1:0], advance, and pointer state → one-hot grant.
- Counter, period timer and FSM stay in the top.

Test Plan:
- Reset release, PERIOD=1, req=01, tgt0=4 → gnt=01 next cycle, value 0,1,2,3,4 on consecutive cycles, done=01 one cycle at value=4, busy drops the cycle after.
- req=11 simultaneously from reset, tgt0=2, tgt1=3 → requester 0 served first (done=01 at value=2), then gnt=10, done=10 at value=3; next collision grants requester 0.
- tgt1=0, req=10 → one RUN cycle, done=10 with value=0, no increment.
- PERIOD=3, tgt0=2 → value steps every 3 cycles; done 8 cycles after req sampled; tgt0 changed to 9 mid-run has no effect.
- Assert rst_n=0 mid-run at value=2 → gnt, done, value, busy all 0 immediately; no done pulse after release; a fresh request runs from 0.
- With STEP_COUNT_SCHED_ABORT_EN, tgt0=15, abort pulsed at value=5 → done=01 and aborted=1 next cycle, value stays 5.

Source files
------------

// File: rtl/step_count_sched_pkg.sv
// Shared types and defaults for the step_count_sched shared stepping-counter scheduler.
package step_count_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int CW_DEF     = 4;
  localparam int PW_DEF     = 8;
  localparam int PERIOD_DEF = 1;

  localparam int REQ0 = 0;
  localparam int REQ1 = 1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: on a collision the pointer side wins; advance moves
// the pointer to the requester that did not win.
module rr_arb2
  import step_count_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic ptr;

  always_comb begin
    gnt = 2'b00;
    if (req[REQ0] && (!req[REQ1] || (ptr == 1'b0))) begin
      gnt = 2'b01;
    end else if (req[REQ1]) begin
      gnt = 2'b10;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (advance && (|req)) begin
      ptr <= gnt[REQ0];
    end
  end

endmodule

// File: rtl/step_count_sched.sv
// Round-robin scheduler owning a shared stepping counter; counts 0..target for the winner
// and pulses its done. Optional abort port pair enabled by STEP_COUNT_SCHED_ABORT_EN.
//
// Handshake: req is a level; the arbiter samples it only in IDLE. gnt stays high for the
// whole run, done pulses one cycle at the end, and req/tgt changes after grant are ignored.
module step_count_sched
  import step_count_sched_pkg::*;
#(
  parameter int PERIOD = PERIOD_DEF,
  parameter int CW     = CW_DEF,
  parameter int PW     = PW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    req,
  input  logic [CW-1:0] tgt0,
  input  logic [CW-1:0] tgt1,
`ifdef STEP_COUNT_SCHED_ABORT_EN
  input  logic          abort,
`endif
  output logic [1:0]    gnt,
  output logic [1:0]    done,
  output logic [CW-1:0] value,
  output logic          busy,
`ifdef STEP_COUNT_SCHED_ABORT_EN
  output logic          aborted,
`endif
  output state_e        dbg_state
);

  state_e        state;
  logic [CW-1:0] tgt_lat;
  logic [PW-1:0] pcnt;
  logic [1:0]    arb_gnt;
  logic          advance;

  assign advance   = (state == IDLE);
  assign dbg_state = state;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .advance (advance),
    .gnt     (arb_gnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      gnt     <= 2'b00;
      done    <= 2'b00;
      value   <= '0;
      busy    <= 1'b0;
      tgt_lat <= '0;
      pcnt    <= '0;
`ifdef STEP_COUNT_SCHED_ABORT_EN
      aborted <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            gnt     <= arb_gnt;
            tgt_lat <= arb_gnt[REQ1] ? tgt1 : tgt0;
            value   <= '0;
            pcnt    <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
`ifdef STEP_COUNT_SCHED_ABORT_EN
          if (abort) begin
            done    <= gnt;
            aborted <= 1'b1;
            state   <= DONE;
          end else
`endif
          // Target check comes before the step so value never passes the target.
          if (value == tgt_lat) begin
            done  <= gnt;
            state <= DONE;
          end else if (pcnt == PW'(PERIOD - 1)) begin
            value <= value + 1'b1;
            pcnt  <= '0;
          end else begin
            pcnt <= pcnt + 1'b1;
          end
        end
        DONE: begin
          gnt   <= 2'b00;
          done  <= 2'b00;
          busy  <= 1'b0;
          state <= IDLE;
`ifdef STEP_COUNT_SCHED_ABORT_EN
          aborted <= 1'b0;
`endif
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
